// File: rtl/bubble_sort_seq.sv
`timescale 1ns/100ps
// ----------------------------------------------------------------------------
// bubble_sort_seq
// Sequential in-place bubble sorter over a DEPTH-entry register array of
// WIDTH-bit unsigned values. One compare-exchange per clock. A pass with no
// swap ends the run early. The sort order is latched when a start is accepted.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (clears state and array)
//   wr_en_i     write strobe, honoured only while idle
//   wr_addr_i   write index (ignored when >= DEPTH)
//   wr_data_i   write data
//   start_i     start request, honoured only while idle
//   descend_i   sampled at an accepted start: 0 ascending, 1 descending
//   rd_addr_i   read index
//   rd_data_o   combinational mem[rd_addr_i], 0 when rd_addr_i >= DEPTH
//   busy_o      high while sorting
//   done_o      one-cycle pulse when a sort completes
//   swaps_o     swaps made in the last run, saturating at 16'hFFFF
// ----------------------------------------------------------------------------
module bubble_sort_seq #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             start_i,
    input  logic             descend_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      swaps_o
);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    j_q, j_d;
    logic [AW-1:0]    limit_q, limit_d;
    logic             pass_swapped_q, pass_swapped_d;
    logic             mode_q, mode_d;
    logic [15:0]      swaps_q, swaps_d;

    logic [AW-1:0]    j_inc;
    logic [WIDTH-1:0] elem_a, elem_b;
    logic             out_of_order;
    logic             pass_end;
    logic             wr_ok, rd_ok;

    // Addresses past DEPTH only exist when DEPTH is not a power of two.
    assign wr_ok = ({1'b0, wr_addr_i} < (AW+1)'(DEPTH));
    assign rd_ok = ({1'b0, rd_addr_i} < (AW+1)'(DEPTH));

    // j never exceeds DEPTH-2 during a sort, so j+1 always stays in range.
    assign j_inc  = j_q + AW'(1);
    assign elem_a = mem_q[j_q];
    assign elem_b = mem_q[j_inc];
    // Strict compares: equal neighbours stay put, which keeps the sort stable.
    assign out_of_order = mode_q ? (elem_a < elem_b) : (elem_a > elem_b);
    assign pass_end     = (j_q == limit_q - AW'(1));

    always_comb begin
        // NOTE: every variable gets a default before the case, otherwise the
        // paths that do not assign it would infer a latch.
        state_d        = state_q;
        mem_d          = mem_q;
        j_d            = j_q;
        limit_d        = limit_q;
        pass_swapped_d = pass_swapped_q;
        mode_d         = mode_q;
        swaps_d        = swaps_q;

        case (state_q)
            IDLE: begin
                // A write in the start cycle lands in the array on the same
                // edge, so the first compare already sees it.
                if (wr_en_i && wr_ok) begin
                    mem_d[wr_addr_i] = wr_data_i;
                end
                if (start_i) begin
                    state_d        = SORT;
                    j_d            = '0;
                    limit_d        = AW'(DEPTH - 1);
                    pass_swapped_d = 1'b0;
                    swaps_d        = '0;
                    mode_d         = descend_i;
                end
            end
            SORT: begin
                if (out_of_order) begin
                    mem_d[j_q]     = elem_b;
                    mem_d[j_inc]   = elem_a;
                    pass_swapped_d = 1'b1;
                    if (swaps_q != 16'hFFFF) begin
                        swaps_d = swaps_q + 16'd1;
                    end
                end
                if (!pass_end) begin
                    j_d = j_inc;
                end else if (!(pass_swapped_q || out_of_order) ||
                             limit_q == AW'(1)) begin
                    state_d = DONE;
                end else begin
                    // The largest (or smallest) element has bubbled to the
                    // tail, so the next pass can stop one slot earlier.
                    limit_d        = limit_q - AW'(1);
                    j_d            = '0;
                    pass_swapped_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            j_q            <= '0;
            limit_q        <= '0;
            pass_swapped_q <= 1'b0;
            mode_q         <= 1'b0;
            swaps_q        <= '0;
            // NOTE: the array is plain flops that must read back as zero
            // after reset, so it is cleared here like any other register
            // instead of being left to power-up values.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values and the swap reads both old entries.
            state_q        <= state_d;
            mem_q          <= mem_d;
            j_q            <= j_d;
            limit_q        <= limit_d;
            pass_swapped_q <= pass_swapped_d;
            mode_q         <= mode_d;
            swaps_q        <= swaps_d;
        end
    end

    assign rd_data_o = rd_ok ? mem_q[rd_addr_i] : '0;
    assign busy_o    = (state_q == SORT);
    assign done_o    = (state_q == DONE);
    assign swaps_o   = swaps_q;

endmodule
